// File: rtl/cbus_pkg.sv
// Shared cbus request/response payload types between the caches, the arbiter
// and the memory-side bridge.
package cbus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strobe;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter granting whole cbus bursts from the cache miss ports to
// the single memory-side cbus; responses go back only to the granted port.
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_BIT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  cbus_req_t          ireqs  [NUM_PORTS],
    output cbus_resp_t         iresps [NUM_PORTS],
    output cbus_req_t          oreq,
    input  cbus_resp_t         oresp,
    output logic               busy,
    output logic [IDX_BIT-1:0] grant_idx,
    output logic               err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    cbus_req_t          saved_req, saved_n;
    logic [IDX_BIT-1:0] grant_n;
    logic [LEN_W-1:0]   beat_cnt, beat_cnt_n;
    logic               err_n;

    logic               found;
    logic [IDX_BIT-1:0] win;
    logic [IDX_BIT-1:0] cand;

    // Scan starts one past the last grant so every port gets its turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_BIT'((32'(grant_idx) + k) % NUM_PORTS);
            if (!found && ireqs[cand].valid) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            saved_req <= '0;
            grant_idx <= IDX_BIT'(NUM_PORTS - 1);
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            saved_req <= saved_n;
            grant_idx <= grant_n;
            beat_cnt  <= beat_cnt_n;
            err       <= err_n;
        end
    end

    // Next-state: latch the winner in IDLE, count beats and close out in BUSY.
    always_comb begin
        state_n    = state;
        saved_n    = saved_req;
        grant_n    = grant_idx;
        beat_cnt_n = beat_cnt;
        err_n      = err;
        case (state)
            IDLE: begin
                if (found) begin
                    saved_n    = ireqs[win];
                    grant_n    = win;
                    beat_cnt_n = '0;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                if (oresp.ready) begin
                    beat_cnt_n = beat_cnt + LEN_W'(1);
                    if (oresp.last) begin
                        state_n = IDLE;
                        if (beat_cnt != saved_req.len) begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only; responses are steered
    // to the granted port and every other port sees zero.
    always_comb begin
        oreq = '0;
        busy = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            oreq              = saved_req;
            oreq.valid        = 1'b1;
            busy              = 1'b1;
            iresps[grant_idx] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: grant order, burst routing, request hold,
// beat-count error flag and mid-burst reset.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [2];
    cbus_resp_t iresps [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] grant_idx;
    logic       err;

    int checks = 0;
    int errors = 0;

    cbus_arbiter #(.NUM_PORTS(2), .IDX_BIT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_busy"},   128'(busy), 128'(0));
        check({tag, "_oreq"},   128'(oreq), 128'(0));
        check({tag, "_iresp0"}, 128'(iresps[0]), 128'(0));
        check({tag, "_iresp1"}, 128'(iresps[1]), 128'(0));
    endtask

    task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [3:0] strb);
        ireqs[p].valid    = 1'b1;
        ireqs[p].is_write = wr;
        ireqs[p].addr     = addr;
        ireqs[p].len      = len;
        ireqs[p].data     = 32'h5A5A_0000 + 32'(p);
        ireqs[p].strobe   = strb;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory side delivers nbeats ready beats; client drops valid with its last beat.
    task automatic burst(input int p, input int nbeats, input logic [31:0] addr_exp,
                         input logic [31:0] dbase, input bit stall);
        for (int b = 1; b <= nbeats; b++) begin
            if (stall && b == 2) begin
                @(negedge clk);
                oresp.ready = 1'b0;
                oresp.last  = 1'b1;
                oresp.data  = 32'hDEAD_BEEF;
                #1;
                check("stall_ready", 128'(iresps[p].ready), 128'(0));
                check("stall_busy",  128'(busy), 128'(1));
            end
            @(negedge clk);
            oresp.ready = 1'b1;
            oresp.last  = (b == nbeats);
            oresp.data  = dbase + 32'(b);
            if (b == nbeats) ireqs[p].valid = 1'b0;
            #1;
            check("beat_ready", 128'(iresps[p].ready), 128'(1));
            check("beat_data",  128'(iresps[p].data), 128'(dbase + 32'(b)));
            check("beat_last",  128'(iresps[p].last), 128'(b == nbeats));
            check("beat_other", 128'(iresps[1-p]), 128'(0));
            check("beat_valid", 128'(oreq.valid), 128'(1));
            check("beat_addr",  128'(oreq.addr), 128'(addr_exp));
        end
        @(negedge clk);
        oresp = '0;
        #1;
        idle_check("post_burst");
    endtask

    initial begin
        reset    = 1'b1;
        ireqs[0] = '0;
        ireqs[1] = '0;
        oresp    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        idle_check("rst");
        check("rst_grant", 128'(grant_idx), 128'(1));
        check("rst_err",   128'(err), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        idle_check("idle_novalid");

        // Single 16-beat read from port 0 with one ignored not-ready last
        set_req(0, 1'b0, 32'h8000_0040, 8'd15, 4'h0);
        #1;
        check("t1_lat0_valid", 128'(oreq.valid), 128'(0));
        @(negedge clk);
        check("t1_lat1_valid", 128'(oreq.valid), 128'(1));
        check("t1_addr",       128'(oreq.addr), 128'(32'h8000_0040));
        check("t1_len",        128'(oreq.len), 128'(15));
        check("t1_grant",      128'(grant_idx), 128'(0));
        check("t1_busy",       128'(busy), 128'(1));
        burst(0, 16, 32'h8000_0040, 32'hA000_0000, 1'b1);
        check("t1_err", 128'(err), 128'(0));

        // Simultaneous valids right after reset: port 0 then port 1
        do_reset();
        check("t2_grant_rst", 128'(grant_idx), 128'(1));
        set_req(0, 1'b0, 32'h0000_0100, 8'd3, 4'h0);
        set_req(1, 1'b0, 32'h0000_0200, 8'd3, 4'h0);
        @(negedge clk);
        check("t2_grant_a", 128'(grant_idx), 128'(0));
        burst(0, 4, 32'h0000_0100, 32'hB000_0000, 1'b0);
        check("t2_gap_grant", 128'(grant_idx), 128'(0));
        @(negedge clk);
        check("t2_grant_b", 128'(grant_idx), 128'(1));
        check("t2_busy_b",  128'(busy), 128'(1));
        burst(1, 4, 32'h0000_0200, 32'hB100_0000, 1'b0);

        // Continuous valids on both ports alternate grants
        ireqs[0].valid = 1'b1;
        ireqs[1].valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_grant", 128'(grant_idx), 128'(k % 2));
            check("t3_busy",  128'(busy), 128'(1));
            burst(k % 2, 4, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200,
                  32'hC000_0000 + 32'(k * 16), 1'b0);
            if (k < 3) ireqs[k % 2].valid = 1'b1;
            else       ireqs[0].valid = 1'b0;
        end

        // Request held while the client changes its address mid-burst
        set_req(1, 1'b1, 32'h0000_1000, 8'd7, 4'hF);
        @(negedge clk);
        check("t4_grant",  128'(grant_idx), 128'(1));
        check("t4_write",  128'(oreq.is_write), 128'(1));
        check("t4_strobe", 128'(oreq.strobe), 128'(4'hF));
        ireqs[1].addr = 32'h0000_2000;
        burst(1, 8, 32'h0000_1000, 32'hD000_0000, 1'b0);

        // Beat mismatch sets sticky err
        set_req(0, 1'b0, 32'h0000_0300, 8'd3, 4'h0);
        @(negedge clk);
        check("t5_grant", 128'(grant_idx), 128'(0));
        burst(0, 2, 32'h0000_0300, 32'hE000_0000, 1'b0);
        check("t5_err", 128'(err), 128'(1));
        set_req(1, 1'b0, 32'h0000_0400, 8'd3, 4'h0);
        @(negedge clk);
        check("t5_grant_good", 128'(grant_idx), 128'(1));
        burst(1, 4, 32'h0000_0400, 32'hE100_0000, 1'b0);
        check("t5_err_sticky", 128'(err), 128'(1));

        // Reset on beat 5 of a 16-beat burst
        set_req(0, 1'b0, 32'h8000_0040, 8'd15, 4'h0);
        @(negedge clk);
        check("t6_grant", 128'(grant_idx), 128'(0));
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            oresp.ready = 1'b1;
            oresp.last  = 1'b0;
            oresp.data  = 32'hF000_0000 + 32'(b);
        end
        @(negedge clk);
        oresp.data     = 32'hF000_0005;
        reset          = 1'b1;
        ireqs[0].valid = 1'b0;
        @(negedge clk);
        idle_check("t6_rst");
        check("t6_grant_rst", 128'(grant_idx), 128'(1));
        check("t6_err_rst",   128'(err), 128'(0));
        reset = 1'b0;
        oresp = '0;
        set_req(1, 1'b0, 32'h0000_0500, 8'd1, 4'h0);
        @(negedge clk);
        check("t6_grant_p1", 128'(grant_idx), 128'(1));
        check("t6_busy_p1",  128'(busy), 128'(1));
        burst(1, 2, 32'h0000_0500, 32'hF100_0000, 1'b0);
        check("t6_err_end", 128'(err), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
